// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one uartTX among N_REQ byte requesters:
// grants one requester, launches its frame, then waits for done or a timeout.
module uart_tx_scheduler #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 131072
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [N_REQ*DATA_W-1:0]  i_data,
  output logic [N_REQ-1:0]         o_ack,
  output logic [$clog2(N_REQ)-1:0] o_grant_id,
  output logic                     o_tx_start,
  output logic [DATA_W-1:0]        o_tx_data,
  input  logic                     i_tx_busy,
  input  logic                     i_tx_done,
  output logic                     o_idle,
  output logic                     o_timeout
);
  localparam int unsigned ID_W  = $clog2(N_REQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timeout_q, timeout_d;

  logic              launch_c;
  logic              cnt_tc_c;
  logic [ID_W-1:0]   win_id_c;
  logic [DATA_W-1:0] win_byte_c;
  logic [ID_W-1:0]   hi_id, lo_id;
  logic              hi_found, lo_found;

  assign launch_c = (state_q == S_IDLE) && !i_tx_busy && (|i_req);
  assign cnt_tc_c = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // Winner: lowest set request at or above the pointer, else lowest overall.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (i_req[k] && !lo_found) begin
        lo_found = 1'b1;
        lo_id    = ID_W'(k);
      end
      if (i_req[k] && !hi_found && (ID_W'(k) >= ptr_q)) begin
        hi_found = 1'b1;
        hi_id    = ID_W'(k);
      end
    end
    win_id_c = hi_found ? hi_id : lo_id;
  end

  always_comb begin
    win_byte_c = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (ID_W'(k) == win_id_c) win_byte_c = i_data[k*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (launch_c) state_d = S_LAUNCH;
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT:   if (i_tx_done || cnt_tc_c) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Done wins over the terminal count; the counter stops at terminal count.
  always_comb begin
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    tx_data_d = tx_data_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (launch_c) begin
          tx_data_d = win_byte_c;
          grant_d   = win_id_c;
          ptr_d     = (win_id_c == ID_W'(N_REQ - 1)) ? '0 : win_id_c + ID_W'(1);
        end
      end
      S_LAUNCH: cnt_d = '0;
      S_WAIT: begin
        if (!i_tx_done) begin
          if (cnt_tc_c) timeout_d = 1'b1;
          else          cnt_d     = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      ptr_q     <= '0;
      grant_q   <= '0;
      tx_data_q <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      tx_data_q <= tx_data_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    o_idle     = 1'b0;
    o_tx_start = 1'b0;
    o_ack      = '0;
    case (state_q)
      S_IDLE: o_idle = 1'b1;
      S_LAUNCH: begin
        o_tx_start = 1'b1;
        o_ack      = N_REQ'(1) << grant_q;
      end
      default: ;
    endcase
  end

  assign o_grant_id = grant_q;
  assign o_tx_data  = tx_data_q;
  assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: vector table, directed corner sequences and a
// randomized run against a transaction-level reference model.
module tb_uart_tx_scheduler;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] data;
  logic           busy, done;

  logic [N-1:0] ack, ack_t;
  logic [1:0]   gid, gid_t;
  logic         start, start_t, idle, idle_t, tmo, tmo_t;
  logic [W-1:0] txd, txd_t;

  always #5 clk = ~clk;

  uart_tx_scheduler #(.N_REQ(N), .DATA_W(W)) u_dut (
    .i_clk(clk), .i_rst(rst_n), .i_req(req), .i_data(data),
    .o_ack(ack), .o_grant_id(gid), .o_tx_start(start), .o_tx_data(txd),
    .i_tx_busy(busy), .i_tx_done(done), .o_idle(idle), .o_timeout(tmo)
  );

  uart_tx_scheduler #(.N_REQ(N), .DATA_W(W), .TIMEOUT_CYC(16)) u_to (
    .i_clk(clk), .i_rst(rst_n), .i_req(req), .i_data(data),
    .o_ack(ack_t), .o_grant_id(gid_t), .o_tx_start(start_t), .o_tx_data(txd_t),
    .i_tx_busy(busy), .i_tx_done(done), .o_idle(idle_t), .o_timeout(tmo_t)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  // reference model: expected frame phase, pointer and latched grant
  bit           m_idle = 1'b1;
  bit           m_launch = 1'b0;
  bit           m_wait = 1'b0;
  int           m_ptr = 0;
  int           m_grant = 0;
  logic [W-1:0] m_data = '0;

  // uartTX stand-in
  bit uart_en = 1'b0;
  bit noise = 1'b0;
  int uart_cnt = -1;
  int lat_min = 0;
  int lat_max = 0;

  typedef struct {
    logic [N-1:0] req;
    int           grant;
    logic [W-1:0] exp_byte;
  } vec_t;
  vec_t tbl [10];

  logic [W-1:0] rr_exp [5];
  logic [W-1:0] rbytes [N][8];
  int           nbytes [N];
  int           sent   [N];
  bit           hold   [N];

  function automatic void check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h, want %h", name, cyc, act, exp);
  endfunction

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) begin
      if (r[(p + i) % N]) return (p + i) % N;
    end
    return 0;
  endfunction

  // Advance the model by one cycle using the inputs applied during the last cycle.
  function automatic void model_advance();
    int w;
    if (!rst_n) begin
      m_idle = 1'b1; m_launch = 1'b0; m_wait = 1'b0;
      m_ptr = 0; m_grant = 0; m_data = '0;
      return;
    end
    if (m_launch) begin
      m_launch = 1'b0;
      m_wait = 1'b1;
    end else if (m_wait) begin
      if (done) begin
        m_wait = 1'b0;
        m_idle = 1'b1;
      end
    end else if (!busy && req != '0) begin
      w = rr_pick(req, m_ptr);
      m_grant = w;
      m_data = data[w*W +: W];
      m_ptr = (w + 1) % N;
      m_idle = 1'b0;
      m_launch = 1'b1;
    end
  endfunction

  task automatic uart_drive();
    busy = 1'b0;
    done = 1'b0;
    if (start) begin
      uart_cnt = $urandom_range(lat_max, lat_min);
      if (noise && $urandom_range(3, 0) == 0) done = 1'b1;
    end else if (uart_cnt > 0) begin
      busy = 1'b1;
      uart_cnt--;
    end else if (uart_cnt == 0) begin
      done = 1'b1;
      uart_cnt = -1;
    end else if (noise) begin
      busy = ($urandom_range(7, 0) == 0);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    model_advance();
    check("model", {tmo, idle, start, ack, gid, txd},
          {1'b0, m_idle, m_launch, m_launch ? 4'(1 << m_grant) : 4'b0, 2'(m_grant), m_data});
    if (uart_en) uart_drive();
  endtask

  task automatic run_grant(input logic [N-1:0] r, input int g, input logic [W-1:0] b);
    req = r;
    step();
    check("vec_launch", {start, ack, gid, txd}, {1'b1, 4'(1 << g), 2'(g), b});
    req = '0;
    step();
    done = 1'b1;
    step();
    done = 1'b0;
    check("vec_idle", idle, 1'b1);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int g = 0;
    req = '0;
    while (!(m_idle && uart_cnt < 0) && g < 200) begin
      step();
      g++;
    end
    check("drain_idle", idle, 1'b1);
  endtask

  initial begin
    int nstart, last, guard, tot_b, tot_s;
    bit all_sent;

    tbl[0] = '{4'b1111, 0, 8'h3C};
    tbl[1] = '{4'b0100, 2, 8'hA5};
    tbl[2] = '{4'b0011, 0, 8'h3C};
    tbl[3] = '{4'b0011, 1, 8'h5A};
    tbl[4] = '{4'b0011, 0, 8'h3C};
    tbl[5] = '{4'b0011, 1, 8'h5A};
    tbl[6] = '{4'b1000, 3, 8'hD3};
    tbl[7] = '{4'b1001, 0, 8'h3C};
    tbl[8] = '{4'b1001, 3, 8'hD3};
    tbl[9] = '{4'b0110, 1, 8'h5A};
    rr_exp[0] = 8'h10; rr_exp[1] = 8'h11; rr_exp[2] = 8'h12;
    rr_exp[3] = 8'h13; rr_exp[4] = 8'h10;

    rst_n = 1'b0; req = '0; data = '0; busy = 1'b0; done = 1'b0;
    #1;
    check("reset_vals", {tmo, idle, start, ack, gid, txd}, {1'b0, 1'b1, 1'b0, 4'b0, 2'd0, 8'h00});
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // single requester, then reset in the middle of the frame
    data = {8'hD3, 8'hA5, 8'h5A, 8'h3C};
    req = 4'b0100;
    step();
    check("single_launch", {start, ack, gid, txd}, {1'b1, 4'b0100, 2'd2, 8'hA5});
    req = '0;
    repeat (5) step();
    check("single_wait", {idle, start}, {1'b0, 1'b0});
    rst_n = 1'b0;
    #1;
    check("reset_mid", {tmo, idle, start, ack, gid, txd}, {1'b0, 1'b1, 1'b0, 4'b0, 2'd0, 8'h00});
    step();
    rst_n = 1'b1;

    // vector table: grant order from a fresh pointer
    for (int i = 0; i < 10; i++) run_grant(tbl[i].req, tbl[i].grant, tbl[i].exp_byte);

    // busy hold-off
    busy = 1'b1;
    req = 4'b0001;
    for (int i = 0; i < 50; i++) begin
      step();
      check("busy_hold", start, 1'b0);
    end
    busy = 1'b0;
    step();
    check("busy_release", {start, ack}, {1'b1, 4'b0001});
    req = '0;
    step();
    done = 1'b1;
    step();
    done = 1'b0;

    // round-robin with all requesters held, uartTX busy 20 cycles then done
    pulse_reset();
    data = {8'h13, 8'h12, 8'h11, 8'h10};
    req = '1;
    uart_en = 1'b1; noise = 1'b0; lat_min = 20; lat_max = 20; uart_cnt = -1;
    nstart = 0; last = 0; guard = 0;
    while (nstart < 5 && guard < 300) begin
      step();
      guard++;
      if (start) begin
        check("rr_byte", txd, rr_exp[nstart]);
        if (nstart > 0) check("rr_gap", 48'(cyc - last), 48'd23);
        last = cyc;
        nstart++;
      end
    end
    check("rr_count", 48'(nstart), 48'd5);
    drain();
    uart_en = 1'b0;
    busy = 1'b0;
    done = 1'b0;

    // timeout on the short-timeout instance, done never returned
    pulse_reset();
    req = 4'b0001;
    step();
    check("to_launch", start_t, 1'b1);
    req = '0;
    for (int i = 1; i <= 18; i++) begin
      step();
      check("to_pulse", tmo_t, (i == 17));
      check("to_idle", idle_t, (i >= 17));
    end
    done = 1'b1;
    step();
    done = 1'b0;

    // done coincides with the terminal count: no timeout
    req = 4'b0001;
    step();
    check("tc_launch", start_t, 1'b1);
    req = '0;
    for (int i = 1; i <= 18; i++) begin
      step();
      check("tc_no_pulse", tmo_t, 1'b0);
      check("tc_idle", idle_t, (i >= 17));
      done = (i == 16);
    end
    done = 1'b0;

    // randomized traffic with busy glitches and done during LAUNCH
    pulse_reset();
    uart_en = 1'b1; noise = 1'b1; lat_min = 0; lat_max = 12; uart_cnt = -1;
    tot_b = 0;
    for (int k = 0; k < N; k++) begin
      nbytes[k] = $urandom_range(8, 3);
      sent[k] = 0;
      hold[k] = 1'b0;
      tot_b += nbytes[k];
      for (int j = 0; j < 8; j++) rbytes[k][j] = W'($urandom);
    end
    guard = 0;
    all_sent = 1'b0;
    while (!(all_sent && m_idle) && guard < 5000) begin
      step();
      guard++;
      for (int k = 0; k < N; k++) begin
        if (ack[k]) begin
          check("rnd_byte", txd, rbytes[k][sent[k] % 8]);
          sent[k]++;
          hold[k] = 1'b0;
        end
      end
      all_sent = 1'b1;
      for (int k = 0; k < N; k++) begin
        if (!hold[k] && sent[k] < nbytes[k] && $urandom_range(3, 0) == 0) hold[k] = 1'b1;
        req[k] = hold[k];
        data[k*W +: W] = hold[k] ? rbytes[k][sent[k]] : W'($urandom);
        if (sent[k] < nbytes[k]) all_sent = 1'b0;
      end
    end
    tot_s = 0;
    for (int k = 0; k < N; k++) tot_s += sent[k];
    check("rnd_total", 48'(tot_s), 48'(tot_b));
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
